// File: rtl/waveform_packetizer.sv
// Frames a raw 32-bit sample stream into header-prefixed AXI-Stream packets.
// Define WFPKT_CHECKSUM_EN to append an XOR trailer word to every packet.
module waveform_packetizer #(
  parameter logic [31:0] CMD_WORD  = 32'h57574441,
  parameter int unsigned PKT_WORDS = 1004,
  parameter logic [31:0] RSVD_WORD = 32'h0000_0000
) (
  input  logic        axi_tclk,
  input  logic        axi_treset,
  input  logic        start,
  input  logic [31:0] wf_id,
  input  logic [31:0] wf_len,
  output logic        busy,
  output logic        done,
  output logic        err_early_tlast,
  input  logic [31:0] s_axis_tdata,
  input  logic        s_axis_tvalid,
  input  logic        s_axis_tlast,
  output logic        s_axis_tready,
  output logic [31:0] m_axis_tdata,
  output logic        m_axis_tvalid,
  output logic        m_axis_tlast,
  output logic [3:0]  m_axis_tkeep,
  input  logic        m_axis_tready
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned LEN_W  = 16;

`ifdef WFPKT_CHECKSUM_EN
  typedef enum logic [3:0] {
    IDLE, HDR_CMD, HDR_ID, HDR_IDX, HDR_LEN, HDR_RSVD, PAYLOAD, TRAILER, DONE
  } state_t;
`else
  typedef enum logic [3:0] {
    IDLE, HDR_CMD, HDR_ID, HDR_IDX, HDR_LEN, HDR_RSVD, PAYLOAD, DONE
  } state_t;
`endif

  state_t              state_q;
  state_t              hdr_next_c;
  logic [DATA_W-1:0]   id_q, remaining_q, index_q;
  logic [LEN_W-1:0]    plen_q, pkt_cnt_q, plen_d;
  logic [DATA_W-1:0]   m_tdata_q, hdr_word_c;
  logic                m_tvalid_q, m_tlast_q;
  logic                busy_q, done_q, err_q;
  logic                load_c, s_fire_c, last_word_c;
`ifdef WFPKT_CHECKSUM_EN
  logic [DATA_W-1:0]   csum_q;
`endif

  function automatic logic [LEN_W-1:0] clamp_len(input logic [DATA_W-1:0] n);
    if (n < DATA_W'(PKT_WORDS)) return n[LEN_W-1:0];
    return LEN_W'(PKT_WORDS);
  endfunction

  // Output register accepts a new word whenever it is empty or being drained.
  assign load_c        = !m_tvalid_q || m_axis_tready;
  assign s_axis_tready = (state_q == PAYLOAD) && load_c;
  assign s_fire_c      = s_axis_tvalid && s_axis_tready;
  assign last_word_c   = (pkt_cnt_q == LEN_W'(1));
  assign plen_d        = clamp_len((state_q == IDLE) ? wf_len : remaining_q);

  assign m_axis_tdata    = m_tdata_q;
  assign m_axis_tvalid   = m_tvalid_q;
  assign m_axis_tlast    = m_tlast_q;
  assign m_axis_tkeep    = {4{m_tvalid_q}};
  assign busy            = busy_q;
  assign done            = done_q;
  assign err_early_tlast = err_q;

  // Header word and successor for the current header state.
  always_comb begin
    hdr_word_c = CMD_WORD;
    hdr_next_c = HDR_ID;
    case (state_q)
      HDR_ID:   begin hdr_word_c = id_q;            hdr_next_c = HDR_IDX;  end
      HDR_IDX:  begin hdr_word_c = index_q;         hdr_next_c = HDR_LEN;  end
      HDR_LEN:  begin hdr_word_c = DATA_W'(plen_q); hdr_next_c = HDR_RSVD; end
      HDR_RSVD: begin hdr_word_c = RSVD_WORD;       hdr_next_c = PAYLOAD;  end
      default:  ;
    endcase
  end

  always_ff @(posedge axi_tclk or posedge axi_treset) begin
    if (axi_treset) begin
      state_q     <= IDLE;
      id_q        <= '0;
      remaining_q <= '0;
      index_q     <= '0;
      plen_q      <= '0;
      pkt_cnt_q   <= '0;
      m_tdata_q   <= '0;
      m_tvalid_q  <= 1'b0;
      m_tlast_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
`ifdef WFPKT_CHECKSUM_EN
      csum_q      <= '0;
`endif
    end else begin
      done_q <= 1'b0;
      if (load_c) m_tvalid_q <= 1'b0;
      case (state_q)
        // CMD word loads straight from IDLE so it is valid the cycle after start.
        IDLE: begin
          if (done_q) begin
            busy_q <= 1'b0;
          end else if (start) begin
            err_q <= 1'b0;
            if (wf_len == '0) begin
              done_q <= 1'b1;
            end else begin
              id_q        <= wf_id;
              remaining_q <= wf_len;
              index_q     <= '0;
              plen_q      <= plen_d;
              pkt_cnt_q   <= plen_d;
              m_tdata_q   <= CMD_WORD;
              m_tvalid_q  <= 1'b1;
              m_tlast_q   <= 1'b0;
              busy_q      <= 1'b1;
              state_q     <= HDR_ID;
`ifdef WFPKT_CHECKSUM_EN
              csum_q      <= '0;
`endif
            end
          end
        end
        HDR_CMD, HDR_ID, HDR_IDX, HDR_LEN, HDR_RSVD: begin
          if (load_c) begin
            m_tdata_q  <= hdr_word_c;
            m_tvalid_q <= 1'b1;
            m_tlast_q  <= 1'b0;
            state_q    <= hdr_next_c;
            if (state_q == HDR_CMD) begin
              plen_q    <= plen_d;
              pkt_cnt_q <= plen_d;
              index_q   <= index_q + DATA_W'(1);
`ifdef WFPKT_CHECKSUM_EN
              csum_q    <= '0;
`endif
            end
          end
        end
        PAYLOAD: begin
          if (s_fire_c) begin
            m_tdata_q   <= s_axis_tdata;
            m_tvalid_q  <= 1'b1;
            pkt_cnt_q   <= pkt_cnt_q - LEN_W'(1);
            remaining_q <= remaining_q - DATA_W'(1);
            if (s_axis_tlast && remaining_q != DATA_W'(1)) err_q <= 1'b1;
`ifdef WFPKT_CHECKSUM_EN
            csum_q    <= csum_q ^ s_axis_tdata;
            m_tlast_q <= 1'b0;
            if (last_word_c) state_q <= TRAILER;
`else
            m_tlast_q <= last_word_c;
            if (last_word_c) state_q <= (remaining_q == DATA_W'(1)) ? DONE : HDR_CMD;
`endif
          end
        end
`ifdef WFPKT_CHECKSUM_EN
        TRAILER: begin
          if (load_c) begin
            m_tdata_q  <= csum_q;
            m_tvalid_q <= 1'b1;
            m_tlast_q  <= 1'b1;
            state_q    <= (remaining_q == '0) ? DONE : HDR_CMD;
          end
        end
`endif
        // Hold until the final tlast word has left the output register.
        DONE: begin
          if (load_c) begin
            done_q  <= 1'b1;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_waveform_packetizer.sv
// Directed self-checking bench for waveform_packetizer (PKT_WORDS=4).
module tb_waveform_packetizer;

  localparam logic [31:0] CMD = 32'h57574441;
`ifdef WFPKT_CHECKSUM_EN
  localparam int TRL = 1;
`else
  localparam int TRL = 0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [31:0] wf_id = '0, wf_len = '0;
  logic        busy, done, err;
  logic [31:0] s_tdata = '0;
  logic        s_tvalid = 1'b0, s_tlast = 1'b0, s_tready;
  logic [31:0] m_tdata;
  logic        m_tvalid, m_tlast;
  logic [3:0]  m_tkeep;
  logic        m_tready = 1'b0;

  always #5 clk = ~clk;

  waveform_packetizer #(.CMD_WORD(CMD), .PKT_WORDS(4), .RSVD_WORD(32'h0)) dut (
    .axi_tclk(clk), .axi_treset(rst), .start(start), .wf_id(wf_id), .wf_len(wf_len),
    .busy(busy), .done(done), .err_early_tlast(err),
    .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tlast(s_tlast),
    .s_axis_tready(s_tready), .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid),
    .m_axis_tlast(m_tlast), .m_axis_tkeep(m_tkeep), .m_axis_tready(m_tready)
  );

  int          n_pass = 0;
  int          n_total = 0;
  logic [31:0] exp_d[$];
  logic        exp_l[$];
  logic [31:0] got[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_total++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_tvalid"}, 32'(m_tvalid), 32'd0);
    chk({tag, "_tdata"},  m_tdata, 32'd0);
    chk({tag, "_tlast"},  32'(m_tlast), 32'd0);
    chk({tag, "_tkeep"},  32'(m_tkeep), 32'd0);
    chk({tag, "_busy"},   32'(busy), 32'd0);
    chk({tag, "_done"},   32'(done), 32'd0);
    chk({tag, "_err"},    32'(err), 32'd0);
    chk({tag, "_sready"}, 32'(s_tready), 32'd0);
  endtask

  // Expected packet stream: header, payload (samples base+k), optional XOR trailer.
  task automatic build_expected(input logic [31:0] id, input logic [31:0] len, input logic [31:0] base);
    logic [31:0] rem, idx, k, x, p, v;
    exp_d.delete();
    exp_l.delete();
    rem = len; idx = '0; k = '0;
    while (rem != 0) begin
      p = (rem < 32'd4) ? rem : 32'd4;
      exp_d.push_back(CMD); exp_d.push_back(id); exp_d.push_back(idx);
      exp_d.push_back(p);   exp_d.push_back(32'h0);
      for (int i = 0; i < 5; i++) exp_l.push_back(1'b0);
      x = '0;
      for (int j = 0; j < int'(p); j++) begin
        v = base + k;
        x = x ^ v;
        exp_d.push_back(v);
        exp_l.push_back(TRL == 0 && j == int'(p) - 1);
        k++;
      end
`ifdef WFPKT_CHECKSUM_EN
      exp_d.push_back(x);
      exp_l.push_back(1'b1);
`endif
      rem = rem - p;
      idx++;
    end
  endtask

  task automatic do_start(input logic [31:0] id, input logic [31:0] len);
    start = 1'b1; wf_id = id; wf_len = len;
    s_tvalid = 1'b0; s_tlast = 1'b0; m_tready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    #1;
  endtask

  task automatic run_wave(input logic [31:0] id, input logic [31:0] len, input logic [31:0] base,
                          input bit stall, input int tlast_at, input int stop_after, input bit poke);
    int          sidx = 0, beats = 0, cyc = 0, n_exp;
    bit          prev_stall = 1'b0, early_done = 1'b0;
    logic [31:0] prev_d = '0;
    logic        prev_l = 1'b0;
    build_expected(id, len, base);
    n_exp = exp_d.size();
    got.delete();
    do_start(id, len);
    chk("first_valid", 32'(m_tvalid), 32'd1);
    chk("first_word", m_tdata, CMD);
    chk("busy_on", 32'(busy), 32'd1);
    while (exp_d.size() > 0 && cyc < 3000) begin
      if (stop_after >= 0 && beats == stop_after) return;
      m_tready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      s_tvalid = (sidx < int'(len)) && (stall ? ($urandom_range(0, 2) != 0) : 1'b1);
      s_tdata  = base + 32'(sidx);
      s_tlast  = (sidx == tlast_at);
      start    = poke && (cyc == 5);
      if (poke) begin wf_id = 32'd99; wf_len = 32'd1; end
      #1;
      if (prev_stall) begin
        chk("hold_valid", 32'(m_tvalid), 32'd1);
        chk("hold_data", m_tdata, prev_d);
        chk("hold_last", 32'(m_tlast), 32'(prev_l));
      end
      if (done) early_done = 1'b1;
      if (m_tvalid && m_tready) begin
        chk("word", m_tdata, exp_d.pop_front());
        chk("last", 32'(m_tlast), 32'(exp_l.pop_front()));
        chk("keep", 32'(m_tkeep), 32'hF);
        got.push_back(m_tdata);
        beats++;
      end
      if (s_tvalid && s_tready) sidx++;
      prev_stall = m_tvalid && !m_tready;
      prev_d = m_tdata;
      prev_l = m_tlast;
      @(negedge clk);
      #1;
      cyc++;
    end
    start = 1'b0; s_tvalid = 1'b0; s_tlast = 1'b0; m_tready = 1'b0;
    chk("no_timeout", 32'(exp_d.size()), 32'd0);
    chk("beats", 32'(beats), 32'(n_exp));
    chk("samples_used", 32'(sidx), len);
    if (!stall) chk("no_bubbles", 32'(cyc), 32'(beats));
    chk("no_early_done", 32'(early_done), 32'd0);
    chk("done_pulse", 32'(done), 32'd1);
    @(negedge clk);
    #1;
    chk("done_clear", 32'(done), 32'd0);
    chk("busy_clear", 32'(busy), 32'd0);
  endtask

  initial begin
    @(negedge clk);
    @(negedge clk);
    #1;
    chk_zero("reset");
    rst = 1'b0;
    @(negedge clk);
    #1;

    // 10 words in packets of 4,4,2
    run_wave(32'd7, 32'd10, 32'hA000_0000, 1'b0, -1, -1, 1'b0);
    chk("t1_count", 32'(got.size()), 32'(25 + 3 * TRL));
    chk("t1_p0_cmd", got[0], 32'h57574441);
    chk("t1_p0_id", got[1], 32'h7);
    chk("t1_p0_idx", got[2], 32'h0);
    chk("t1_p0_len", got[3], 32'h4);
    chk("t1_p1_cmd", got[9 + TRL], 32'h57574441);
    chk("t1_p1_idx", got[11 + TRL], 32'h1);
    chk("t1_p1_len", got[12 + TRL], 32'h4);
    chk("t1_p2_id", got[19 + 2 * TRL], 32'h7);
    chk("t1_p2_idx", got[20 + 2 * TRL], 32'h2);
    chk("t1_p2_len", got[21 + 2 * TRL], 32'h2);
    chk("t1_err", 32'(err), 32'd0);

    // same waveform with back-pressure, gapped source and a start while busy
    run_wave(32'd7, 32'd10, 32'hB000_0000, 1'b1, -1, -1, 1'b1);
    chk("t2_count", 32'(got.size()), 32'(25 + 3 * TRL));

    // zero-length waveform
    do_start(32'd5, 32'd0);
    chk("z_done", 32'(done), 32'd1);
    chk("z_busy", 32'(busy), 32'd0);
    chk("z_valid", 32'(m_tvalid), 32'd0);
    @(negedge clk);
    #1;
    chk("z_done_clear", 32'(done), 32'd0);
    chk("z_busy2", 32'(busy), 32'd0);
    chk("z_valid2", 32'(m_tvalid), 32'd0);

    // reset in the payload of packet 1, then a fresh 3-word run
    run_wave(32'd7, 32'd10, 32'hC000_0000, 1'b0, -1, 16, 1'b0);
    rst = 1'b1;
    #1;
    chk_zero("midrst");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    run_wave(32'd7, 32'd3, 32'hD000_0000, 1'b0, -1, -1, 1'b0);
    chk("r_count", 32'(got.size()), 32'(8 + TRL));
    chk("r_idx", got[2], 32'h0);
    chk("r_len", got[3], 32'h3);

    // early tlast on sample 2 of 5
    run_wave(32'd8, 32'd5, 32'hE000_0000, 1'b0, 1, -1, 1'b0);
    chk("e_err_set", 32'(err), 32'd1);
    @(negedge clk);
    #1;
    chk("e_err_sticky", 32'(err), 32'd1);
    do_start(32'd9, 32'd0);
    chk("e_err_cleared", 32'(err), 32'd0);
    @(negedge clk);
    #1;

    // payload 1,2,3,4: trailer (when enabled) is 1^2^3^4 = 4
    run_wave(32'd3, 32'd4, 32'd1, 1'b0, -1, -1, 1'b0);
    chk("c_count", 32'(got.size()), 32'(9 + TRL));
    chk("c_len", got[3], 32'h4);
    chk("c_tail", got[8 + TRL], 32'h4);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
